// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, shift schedule, types.
package des_pkg;

  localparam int unsigned ROUNDS = 16;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] subkey_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  // Entries are 1-based DES bit numbers (bit 1 is the MSB).
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFTS [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic half_key_t rotl(input half_key_t h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic half_key_t rotr(input half_key_t h, input logic two);
    return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression: 56-bit {C,D} to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign subkey[47-g] = cd[56-PC2[g]];
  end

  // DES bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule emitting K1..K16 (or K16..K1) with valid/ready handshake.
// Optional DES_KS_PARITY_CHECK_EN adds a registered parity_err output.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        key_ready,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [4:0]  round,
  output logic        last
`ifdef DES_KS_PARITY_CHECK_EN
  ,
  output logic        parity_err
`endif
);

  ks_state_t state_q, state_d;
  half_key_t c_q, c_d, d_q, d_d;
  logic [4:0] round_q, round_d;
  logic       dec_q, dec_d;
  logic [55:0] pc1_cd;
  logic [3:0]  sidx;
  logic        two;
  logic        accept;

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_cd[55-g] = key[64-PC1[g]];
  end

  assign accept = key_valid && (state_q == IDLE);

  // Encrypt pre-rotates at load so step 1 shows K1; decrypt loads C0/D0 (= K16)
  // and then walks the schedule backwards with right rotations.
  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    d_d          = d_q;
    round_d      = round_q;
    dec_d        = dec_q;
    key_ready    = (state_q == IDLE);
    subkey_valid = (state_q == RUN);
    last         = (state_q == RUN) && (round_q == 5'(ROUNDS));
    sidx         = dec_q ? 4'(5'd16 - round_q) : round_q[3:0];
    two          = (SHIFTS[sidx] == 2);
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = RUN;
          round_d = 5'd1;
          dec_d   = decrypt;
          c_d     = decrypt ? pc1_cd[55:28] : rotl(pc1_cd[55:28], 1'b0);
          d_d     = decrypt ? pc1_cd[27:0]  : rotl(pc1_cd[27:0], 1'b0);
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 5'(ROUNDS)) begin
            state_d = IDLE;
            round_d = '0;
          end else begin
            round_d = round_q + 5'd1;
            c_d     = dec_q ? rotr(c_q, two) : rotl(c_q, two);
            d_d     = dec_q ? rotr(d_q, two) : rotl(d_q, two);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign round = round_q;

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

`ifdef DES_KS_PARITY_CHECK_EN
  logic key_par_err;
  // DES keys use odd parity per byte; an even-weight byte is an error.
  assign key_par_err = ~^key[63:56] | ~^key[55:48] | ~^key[47:40] | ~^key[39:32] |
                       ~^key[31:24] | ~^key[23:16] | ~^key[15:8]  | ~^key[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept) begin
      parity_err <= key_par_err;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^{accept, key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8], key[0]};
`endif

endmodule
